// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Direct-mapped, write-back, write-allocate data cache controller
//            with 64-byte lines and 64-bit core-side words.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            dcache_*             - core side (enable/wenable/addr/wdata in,
//                                   rdata/done out)
//            drequest/dwrenable/daddr/dwdata (out), drdata/ddone (in)
//                                 - memory arbiter side, one line per transfer
// Options  : DCACHE_DEBUG_EN - when defined, prints one line per completed
//            access and per memory transfer; cycle behaviour is unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int SETS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         dcache_enable,
    input  logic         dcache_wenable,
    input  logic [63:0]  dcache_addr,
    output logic [63:0]  dcache_rdata,
    input  logic [63:0]  dcache_wdata,
    output logic         dcache_done,
    output logic         drequest,
    output logic         dwrenable,
    output logic [63:0]  daddr,
    input  logic [511:0] drdata,
    output logic [511:0] dwdata,
    input  logic         ddone
);

    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = 58 - c_IDX_W;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WRITEBACK = 2'd1;
    localparam logic [1:0] c_FILL      = 2'd2;
    localparam logic [1:0] c_RESPOND   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;

    logic [SETS-1:0]    r_valid;
    logic [SETS-1:0]    r_dirty;
    logic [c_TAG_W-1:0] r_tag  [SETS];
    logic [511:0]       r_data [SETS];

    // Request captured when IDLE accepts it; the core holds its inputs
    // stable, but the lookup index must not depend on that after acceptance.
    logic [63:3]        r_req_addr;
    logic               r_req_wen;
    logic [63:0]        r_req_wdata;

    logic [c_IDX_W-1:0] w_in_idx;
    logic [c_TAG_W-1:0] w_in_tag;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_req_tag;
    logic [2:0]         w_word;
    logic               w_hit;
    logic               w_victim_dirty;
    logic               w_unused_addr_lsb;

    assign w_in_idx          = dcache_addr[6 +: c_IDX_W];
    assign w_in_tag          = dcache_addr[63 -: c_TAG_W];
    assign w_idx             = r_req_addr[6 +: c_IDX_W];
    assign w_req_tag         = r_req_addr[63 -: c_TAG_W];
    assign w_word            = r_req_addr[5:3];
    assign w_hit             = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);
    assign w_victim_dirty    = r_valid[w_in_idx] && r_dirty[w_in_idx];
    // Byte offset within the word is irrelevant to a 64-bit aligned access.
    assign w_unused_addr_lsb = ^dcache_addr[2:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; ddone only matters in the two transfer states,
    // so a stray pulse while drequest is low is ignored by construction.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (dcache_enable) begin
                    if (w_hit) begin
                        w_next_state = c_RESPOND;
                    end else if (w_victim_dirty) begin
                        w_next_state = c_WRITEBACK;
                    end else begin
                        w_next_state = c_FILL;
                    end
                end
            end
            c_WRITEBACK: if (ddone) w_next_state = c_FILL;
            c_FILL:      if (ddone) w_next_state = c_RESPOND;
            c_RESPOND:   w_next_state = c_IDLE;
            default:     w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state only, so they are held stable for the
    // whole of a transfer and drop to zero the cycle after reset.
    // ------------------------------------------------------------------
    always_comb begin
        dcache_done  = 1'b0;
        dcache_rdata = '0;
        drequest     = 1'b0;
        dwrenable    = 1'b0;
        daddr        = '0;
        dwdata       = '0;
        case (r_state)
            c_WRITEBACK: begin
                drequest  = 1'b1;
                dwrenable = 1'b1;
                daddr     = {r_tag[w_idx], w_idx, 6'b0};
                dwdata    = r_data[w_idx];
            end
            c_FILL: begin
                drequest = 1'b1;
                daddr    = {r_req_addr[63:6], 6'b0};
            end
            c_RESPOND: begin
                dcache_done = 1'b1;
                if (!r_req_wen) begin
                    dcache_rdata = r_data[w_idx][{w_word, 6'b0} +: 64];
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Valid / dirty bits; reset invalidates everything, which also drops
    // any dirty data belonging to an abandoned transaction.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (r_state == c_WRITEBACK && ddone) begin
                r_dirty[w_idx] <= 1'b0;
            end
            if (r_state == c_FILL && ddone) begin
                r_valid[w_idx] <= 1'b1;
            end
            if (r_state == c_RESPOND && r_req_wen) begin
                r_dirty[w_idx] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag / data arrays and request capture (no reset needed: contents
    // are qualified by the valid bits and the state).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == c_IDLE && dcache_enable) begin
                r_req_addr  <= dcache_addr[63:3];
                r_req_wen   <= dcache_wenable;
                r_req_wdata <= dcache_wdata;
            end
            if (r_state == c_FILL && ddone) begin
                r_tag[w_idx]  <= w_req_tag;
                r_data[w_idx] <= drdata;
            end
            if (r_state == c_RESPOND && r_req_wen) begin
                r_data[w_idx][{w_word, 6'b0} +: 64] <= r_req_wdata;
            end
        end
    end

`ifdef DCACHE_DEBUG_EN
    logic r_dbg_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbg_hit <= 1'b0;
        end else if (r_state == c_IDLE && dcache_enable) begin
            r_dbg_hit <= w_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == c_RESPOND) begin
                $display("dcache: %s addr=%h data=%h %s",
                         r_req_wen ? "W" : "R", {r_req_addr, 3'b000},
                         r_req_wen ? r_req_wdata : dcache_rdata,
                         r_dbg_hit ? "hit" : "miss");
            end
            if (drequest && ddone) begin
                $display("dcache: mem %s line=%h",
                         dwrenable ? "writeback" : "fill", daddr);
            end
        end
    end
`else
    // Trace output compiled out; no logic in this branch.
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Purpose  : Self-checking bench for dcache_ctrl: a behavioural memory that
//            answers line transfers, a shadow of the coherent memory image,
//            a read-data scoreboard, directed corner sequences and a table
//            of access vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         dcache_enable;
    logic         dcache_wenable;
    logic [63:0]  dcache_addr;
    logic [63:0]  dcache_rdata;
    logic [63:0]  dcache_wdata;
    logic         dcache_done;
    logic         drequest;
    logic         dwrenable;
    logic [63:0]  daddr;
    logic [511:0] drdata;
    logic [511:0] dwdata;
    logic         ddone;

    always #5 clk = ~clk;

    dcache_ctrl #(.SETS(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .dcache_enable  (dcache_enable),
        .dcache_wenable (dcache_wenable),
        .dcache_addr    (dcache_addr),
        .dcache_rdata   (dcache_rdata),
        .dcache_wdata   (dcache_wdata),
        .dcache_done    (dcache_done),
        .drequest       (drequest),
        .dwrenable      (dwrenable),
        .daddr          (daddr),
        .drdata         (drdata),
        .dwdata         (dwdata),
        .ddone          (ddone)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Backing memory (what the arbiter side holds) and the coherent image
    // (backing memory plus every completed core write).
    logic [511:0] mem    [logic [63:0]];
    logic [511:0] shadow [logic [63:0]];
    logic [63:0]  sb_q   [$];

    // Results of the most recent access.
    int           t_nwb, t_nfill, t_lat, t_extra;
    logic         t_got, t_stable;
    logic [63:0]  t_rd, t_wb_addr, t_fill_addr;
    logic [511:0] t_wb_data;

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wd;
        int          delay;
        int          exp_wb;
        int          exp_fill;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input logic [63:0] la, input int w);
        if (la == 64'h1000) return 64'hAAAA + 64'(w);
        return {la[37:6], 32'hC0DE_0000 + 32'(w)};
    endfunction

    function automatic logic [511:0] mem_line(input logic [63:0] la);
        logic [511:0] l;
        if (mem.exists(la)) return mem[la];
        for (int w = 0; w < 8; w++) l[w*64 +: 64] = init_word(la, w);
        return l;
    endfunction

    function automatic logic [511:0] sh_line(input logic [63:0] la);
        if (shadow.exists(la)) return shadow[la];
        return mem_line(la);
    endfunction

    task automatic do_reset();
        reset          = 1'b1;
        dcache_enable  = 1'b0;
        ddone          = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One core access, acting as the memory arbiter while it is in flight.
    task automatic access(input logic wen, input logic [63:0] addr,
                          input logic [63:0] wd, input int delay);
        logic [63:0]  la, cap_addr;
        logic [511:0] cap_data, line;
        logic         cap_we, in_req;
        int           wait_cnt;
        la = {addr[63:6], 6'b0};
        t_nwb = 0; t_nfill = 0; t_lat = 0; t_extra = 0;
        t_got = 1'b0; t_stable = 1'b1; t_rd = '0;
        in_req = 1'b0; wait_cnt = 0; cap_addr = '0; cap_data = '0; cap_we = 1'b0;
        line = sh_line(la);
        if (wen) begin
            line[int'(addr[5:3])*64 +: 64] = wd;
            shadow[la] = line;
        end else begin
            sb_q.push_back(line[int'(addr[5:3])*64 +: 64]);
        end
        @(negedge clk);
        dcache_enable  = 1'b1;
        dcache_wenable = wen;
        dcache_addr    = addr;
        dcache_wdata   = wd;
        while (!t_got && t_lat < 200) begin
            @(negedge clk);
            t_lat++;
            if (ddone) begin
                ddone  = 1'b0;
                in_req = 1'b0;
            end
            if (dcache_done) begin
                t_got = 1'b1;
                t_rd  = dcache_rdata;
                dcache_enable = 1'b0;
                if (!wen) begin
                    if (sb_q.size() == 0) begin
                        n_total++;
                        $display("FAIL scoreboard: read done at %0h but no expected entry", addr);
                    end else begin
                        chk($sformatf("rdata@%0h", addr), dcache_rdata, sb_q.pop_front());
                    end
                end
            end else if (drequest) begin
                if (!in_req) begin
                    in_req = 1'b1; wait_cnt = 0;
                    cap_addr = daddr; cap_data = dwdata; cap_we = dwrenable;
                    if (dwrenable) begin
                        t_nwb++; t_wb_addr = daddr; t_wb_data = dwdata;
                        chk($sformatf("wb_data@%0h", daddr), dwdata, sh_line(daddr));
                    end else begin
                        t_nfill++; t_fill_addr = daddr;
                        chk($sformatf("fill_addr@%0h", addr), daddr, la);
                    end
                end else if (daddr !== cap_addr || dwdata !== cap_data || dwrenable !== cap_we) begin
                    t_stable = 1'b0;
                end
                if (wait_cnt == delay) begin
                    ddone = 1'b1;
                    if (cap_we) mem[cap_addr] = cap_data;
                    else        drdata = mem_line(cap_addr);
                end
                wait_cnt++;
            end else if (in_req) begin
                t_stable = 1'b0;   // request withdrawn before ddone
            end
        end
        dcache_enable = 1'b0;
        ddone         = 1'b0;
        if (!t_got) begin
            n_total++;
            $display("FAIL timeout@%0h: no done after %0d cycles (required within 200)", addr, t_lat);
        end else begin
            @(negedge clk);
            if (dcache_done) t_extra++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dcache_enable = 1'b0; dcache_wenable = 1'b0; dcache_addr = '0;
        dcache_wdata = '0; drdata = '0; ddone = 1'b0; reset = 1'b1;

        vecs[0]  = '{1'b1, 64'h4088,               64'hA1A1_0000_0000_0001, 0, 0, 1};
        vecs[1]  = '{1'b0, 64'h4088,               64'h0,                   0, 0, 0};
        vecs[2]  = '{1'b1, 64'h4080,               64'hA2A2_0000_0000_0002, 0, 0, 0};
        vecs[3]  = '{1'b0, 64'h8080,               64'h0,                   3, 1, 1};
        vecs[4]  = '{1'b0, 64'h4088,               64'h0,                   1, 0, 1};
        vecs[5]  = '{1'b0, 64'h40B8,               64'h0,                   0, 0, 0};
        vecs[6]  = '{1'b1, 64'h0FF8,               64'hA3A3_0000_0000_0003, 2, 0, 1};
        vecs[7]  = '{1'b0, 64'h0FF8,               64'h0,                   0, 0, 0};
        vecs[8]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hA4A4_0000_0000_0004, 0, 1, 1};
        vecs[9]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,                   0, 0, 0};
        vecs[10] = '{1'b0, 64'h0FC0,               64'h0,                   4, 1, 1};
        vecs[11] = '{1'b0, 64'h0FF8,               64'h0,                   0, 0, 0};
        vecs[12] = '{1'b0, 64'h0FC5,               64'h0,                   0, 0, 0};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_done",      dcache_done,  1'b0);
        chk("rst_drequest",  drequest,     1'b0);
        chk("rst_dwrenable", dwrenable,    1'b0);
        chk("rst_daddr",     daddr,        64'h0);
        chk("rst_dwdata",    dwdata,       512'h0);
        chk("rst_rdata",     dcache_rdata, 64'h0);

        // Stray ddone while idle must be ignored
        ddone = 1'b1;
        @(negedge clk);
        ddone = 1'b0;
        chk("idle_ddone_req",  drequest,    1'b0);
        chk("idle_ddone_done", dcache_done, 1'b0);

        // Cold read miss fills the line
        access(1'b0, 64'h1000, 64'h0, 0);
        chk("r1000_fill", t_nfill, 1);
        chk("r1000_wb",   t_nwb,   0);
        chk("r1000_addr", t_fill_addr, 64'h1000);
        chk("r1000_data", t_rd, 64'hAAAA);
        chk("r1000_lat",  t_lat, 2);

        // Same line now hits with single-cycle latency
        access(1'b0, 64'h1008, 64'h0, 0);
        chk("r1008_fill", t_nfill, 0);
        chk("r1008_lat",  t_lat, 1);
        chk("r1008_data", t_rd, 64'hAAAB);

        // Write hit then read-back from the cache
        access(1'b1, 64'h1010, 64'h1234, 0);
        chk("w1010_lat",  t_lat, 1);
        chk("w1010_fill", t_nfill + t_nwb, 0);
        access(1'b0, 64'h1010, 64'h0, 0);
        chk("r1010_data", t_rd, 64'h1234);
        chk("r1010_mem",  t_nfill + t_nwb, 0);
        chk("r1010_lat",  t_lat, 1);

        // Conflict miss on a dirty line, with a slow arbiter
        access(1'b0, 64'h2000, 64'h0, 20);
        chk("r2000_wb",      t_nwb, 1);
        chk("r2000_wbaddr",  t_wb_addr, 64'h1000);
        chk("r2000_wbword",  t_wb_data[191:128], 64'h1234);
        chk("r2000_fill",    t_nfill, 1);
        chk("r2000_filladr", t_fill_addr, 64'h2000);
        chk("r2000_stable",  t_stable, 1'b1);
        chk("r2000_onedone", t_extra, 0);

        // Dirty a line, then reset in the middle of an unrelated fill
        access(1'b1, 64'h2008, 64'h77, 0);
        chk("w2008_lat", t_lat, 1);
        @(negedge clk);
        dcache_enable = 1'b1; dcache_wenable = 1'b0; dcache_addr = 64'h1040;
        @(negedge clk);
        chk("mid_req",   drequest,  1'b1);
        chk("mid_wr",    dwrenable, 1'b0);
        chk("mid_daddr", daddr,     64'h1040);
        reset = 1'b1; dcache_enable = 1'b0;
        @(negedge clk);
        chk("mid_rst_req",  drequest,    1'b0);
        chk("mid_rst_done", dcache_done, 1'b0);
        reset = 1'b0;
        shadow.delete();
        foreach (mem[k]) shadow[k] = mem[k];
        sb_q.delete();

        access(1'b0, 64'h1000, 64'h0, 0);
        chk("post_rst_miss", t_nfill, 1);
        access(1'b0, 64'h2008, 64'h0, 0);
        chk("post_rst_wb",   t_nwb,   0);
        chk("post_rst_fill", t_nfill, 1);
        chk("dirty_discard", t_rd, init_word(64'h2000, 1));

        // Vector table
        foreach (vecs[i]) begin
            access(vecs[i].wen, vecs[i].addr, vecs[i].wd, vecs[i].delay);
            chk($sformatf("v%0d_wb", i),   t_nwb,   vecs[i].exp_wb);
            chk($sformatf("v%0d_fill", i), t_nfill, vecs[i].exp_fill);
            chk($sformatf("v%0d_one", i),  t_extra, 0);
            if (vecs[i].exp_wb == 0 && vecs[i].exp_fill == 0) begin
                chk($sformatf("v%0d_lat", i), t_lat, 1);
            end
            if (vecs[i].delay > 0) begin
                chk($sformatf("v%0d_stable", i), t_stable, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
